// File: rtl/core_logic_prog_if.sv
// rtl/core_logic_prog_if.sv - rule-table configuration write port for core_logic_prog
interface core_logic_prog_if #(
    parameter int SW = 4,
    parameter int XW = 4,
    parameter int NR = 4
);
    localparam int RW = $clog2(NR);

    logic          CFG_WE;
    logic [SW-1:0] CFG_STATE;
    logic [RW-1:0] CFG_RULE;
    logic          CFG_VALID;
    logic [XW-1:0] CFG_MASK;
    logic [XW-1:0] CFG_MATCH;
    logic [SW-1:0] CFG_NEXT;

    modport master (
        output CFG_WE, CFG_STATE, CFG_RULE, CFG_VALID, CFG_MASK, CFG_MATCH, CFG_NEXT
    );

    modport slave (
        input  CFG_WE, CFG_STATE, CFG_RULE, CFG_VALID, CFG_MASK, CFG_MATCH, CFG_NEXT
    );
endinterface

// File: rtl/core_logic_prog.sv
// rtl/core_logic_prog.sv - table-programmable core logic FSM with LFSR/MISR self-test
module core_logic_prog #(
    parameter int SW = 4,
    parameter int XW = 4,
    parameter int NR = 4
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              TLR,
    input  logic [XW-1:0]     X,
    input  logic              INTEST_SELECT,
    input  logic              RUNBIST_SELECT,
    input  logic              SETSTATE_SELECT,
    input  logic [SW-1:0]     ASSIGN_STATE,
    input  logic [15:0]       BIST_LEN,
    core_logic_prog_if.slave  cfg,
    output logic [SW-1:0]     Y,
    output logic              HIT,
    output logic              BIST_BUSY,
    output logic              BIST_DONE,
    output logic [15:0]       SIGNATURE
);
    localparam int          RW         = $clog2(NR);
    localparam int          NE         = (1 << SW) * NR;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    // Busy and done are the two state bits, so the outputs come straight off the register.
    typedef enum logic [1:0] {
        B_IDLE = 2'b00,
        B_RUN  = 2'b01,
        B_DONE = 2'b10
    } bist_e;

    logic [NE-1:0]      valid_q;
    logic [XW-1:0]      mask_q  [NE];
    logic [XW-1:0]      match_q [NE];
    logic [SW-1:0]      next_q  [NE];

    logic [SW-1:0]      state_q;
    logic               hit_q;
    bist_e              bist_q;
    logic [15:0]        sig_q;
    logic [15:0]        lfsr_q;
    logic [15:0]        cnt_q;
    logic               rb_q;

    logic [SW+RW-1:0]   widx;
    logic [SW+RW-1:0]   ridx;
    logic [XW-1:0]      step_v;
    logic [SW-1:0]      step_state_d;
    logic               step_hit_d;
    logic [15:0]        lfsr_d;
    logic [15:0]        sig_d;

    assign widx = {cfg.CFG_STATE, cfg.CFG_RULE};

    // Scan rules from highest to lowest so the lowest-numbered firing rule is the last to assign.
    always_comb begin
        step_v       = RUNBIST_SELECT ? lfsr_q[XW-1:0] : X;
        step_state_d = state_q;
        step_hit_d   = 1'b0;
        ridx         = '0;
        for (int r = NR - 1; r >= 0; r--) begin
            ridx = {state_q, RW'(r)};
            if (valid_q[ridx] && ((step_v & mask_q[ridx]) == match_q[ridx])) begin
                step_state_d = next_q[ridx];
                step_hit_d   = 1'b1;
            end
        end
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        sig_d  = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ 16'(step_state_d);
    end

    // Rule payload needs no reset: an entry is only consulted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (cfg.CFG_WE) begin
            mask_q[widx]  <= cfg.CFG_MASK;
            match_q[widx] <= cfg.CFG_MATCH;
            next_q[widx]  <= cfg.CFG_NEXT;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q <= '0;
            state_q <= '0;
            hit_q   <= 1'b0;
            bist_q  <= B_IDLE;
            sig_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            rb_q    <= 1'b0;
        end else begin
            if (cfg.CFG_WE) begin
                valid_q[widx] <= cfg.CFG_VALID;
            end
            rb_q <= RUNBIST_SELECT;

            if (TLR) begin
                state_q <= '0;
                hit_q   <= 1'b0;
                bist_q  <= B_IDLE;
                sig_q   <= '0;
                lfsr_q  <= LFSR_SEED;
                cnt_q   <= '0;
                rb_q    <= 1'b0;
            end else if (SETSTATE_SELECT) begin
                state_q <= ASSIGN_STATE;
                hit_q   <= 1'b0;
            end else if (RUNBIST_SELECT) begin
                if (!rb_q) begin
                    state_q <= '0;
                    hit_q   <= 1'b0;
                    sig_q   <= '0;
                    lfsr_q  <= LFSR_SEED;
                    cnt_q   <= BIST_LEN;
                    bist_q  <= (BIST_LEN == 16'd0) ? B_DONE : B_RUN;
                end else if (bist_q == B_RUN) begin
                    state_q <= step_state_d;
                    hit_q   <= step_hit_d;
                    lfsr_q  <= lfsr_d;
                    sig_q   <= sig_d;
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                    if (cnt_q <= 16'd1) begin
                        bist_q <= B_DONE;
                    end
                end
            end else begin
                // Losing the select mid-run abandons it; partial state and signature stay visible.
                if (bist_q == B_RUN) begin
                    bist_q <= B_IDLE;
                end
                if (INTEST_SELECT) begin
                    state_q <= step_state_d;
                    hit_q   <= step_hit_d;
                end
            end
        end
    end

    assign Y         = state_q;
    assign HIT       = hit_q;
    assign BIST_BUSY = (bist_q == B_RUN);
    assign BIST_DONE = (bist_q == B_DONE);
    assign SIGNATURE = sig_q;
endmodule

// File: tb/tb_core_logic_prog.sv
// tb/tb_core_logic_prog.sv - directed scoreboard bench for core_logic_prog
module tb_core_logic_prog;
    localparam int SW = 4;
    localparam int XW = 4;
    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        TLR;
    logic [3:0]  X;
    logic        INTEST_SELECT, RUNBIST_SELECT, SETSTATE_SELECT;
    logic [3:0]  ASSIGN_STATE;
    logic [15:0] BIST_LEN;
    logic [3:0]  Y;
    logic        HIT, BIST_BUSY, BIST_DONE;
    logic [15:0] SIGNATURE;

    core_logic_prog_if #(.SW(SW), .XW(XW), .NR(NR)) cfg_if ();

    core_logic_prog #(.SW(SW), .XW(XW), .NR(NR)) dut (
        .clk             (clk),
        .RESET_N         (RESET_N),
        .TLR             (TLR),
        .X               (X),
        .INTEST_SELECT   (INTEST_SELECT),
        .RUNBIST_SELECT  (RUNBIST_SELECT),
        .SETSTATE_SELECT (SETSTATE_SELECT),
        .ASSIGN_STATE    (ASSIGN_STATE),
        .BIST_LEN        (BIST_LEN),
        .cfg             (cfg_if),
        .Y               (Y),
        .HIT             (HIT),
        .BIST_BUSY       (BIST_BUSY),
        .BIST_DONE       (BIST_DONE),
        .SIGNATURE       (SIGNATURE)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [3:0]  y;
        logic        hit;
        logic        busy;
        logic        done;
        logic [15:0] sig;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   busy_cycles;

    logic       m_valid [16][4];
    logic [3:0] m_mask  [16][4];
    logic [3:0] m_match [16][4];
    logic [3:0] m_next  [16][4];

    logic [3:0]  b_s;
    logic        b_h;
    logic [15:0] b_sig, sig_first;

    task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] y, input logic h,
                        input logic b, input logic d, input logic [15:0] s);
        exp_t e;
        e.tag = tag; e.y = y; e.hit = h; e.busy = b; e.done = d; e.sig = s;
        sbq.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sbq.pop_front();
            chk(e.tag, "Y",    16'(Y),         16'(e.y));
            chk(e.tag, "HIT",  16'(HIT),       16'(e.hit));
            chk(e.tag, "BUSY", 16'(BIST_BUSY), 16'(e.busy));
            chk(e.tag, "DONE", 16'(BIST_DONE), 16'(e.done));
            chk(e.tag, "SIG",  SIGNATURE,      e.sig);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] y, input logic h,
                       input logic b, input logic d, input logic [15:0] s);
        push(tag, y, h, b, d, s);
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic set_cfg(input logic we, input logic [3:0] st, input logic [1:0] r,
                           input logic v, input logic [3:0] mk, input logic [3:0] mt,
                           input logic [3:0] nx);
        cfg_if.CFG_WE    = we;
        cfg_if.CFG_STATE = st;
        cfg_if.CFG_RULE  = r;
        cfg_if.CFG_VALID = v;
        cfg_if.CFG_MASK  = mk;
        cfg_if.CFG_MATCH = mt;
        cfg_if.CFG_NEXT  = nx;
        if (we) begin
            m_valid[st][r] = v;
            m_mask[st][r]  = mk;
            m_match[st][r] = mt;
            m_next[st][r]  = nx;
        end
    endtask

    function automatic void mstep(input logic [3:0] s, input logic [3:0] v,
                                  output logic [3:0] ns, output logic h);
        ns = s;
        h  = 1'b0;
        for (int r = 0; r < NR; r++) begin
            if (!h && m_valid[s][r] && ((v & m_mask[s][r]) == m_match[s][r])) begin
                ns = m_next[s][r];
                h  = 1'b1;
            end
        end
    endfunction

    // Starts a run from a low RUNBIST_SELECT and follows it for 'steps' edges after the start edge.
    task automatic bist_run(input string tag, input logic [15:0] n, input int steps,
                            output logic [3:0] s_o, output logic h_o, output logic [15:0] sig_o);
        logic [3:0]  s, ns;
        logic        h;
        logic [15:0] lf, sg;
        s = 4'h0; h = 1'b0; lf = 16'hACE1; sg = 16'h0;
        BIST_LEN = n;
        RUNBIST_SELECT = 1'b1;
        busy_cycles = 0;
        cyc($sformatf("%s_e0", tag), 4'h0, 1'b0, n != 0, n == 0, 16'h0);
        busy_cycles += int'(BIST_BUSY);
        for (int k = 1; k <= steps; k++) begin
            mstep(s, lf[3:0], ns, h);
            s  = ns;
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
            sg = {sg[14:0], sg[15] ^ sg[13] ^ sg[12] ^ sg[10]} ^ {12'h0, s};
            cyc($sformatf("%s_e%0d", tag, k), s, h, k < int'(n), k == int'(n), sg);
            busy_cycles += int'(BIST_BUSY);
        end
        s_o = s; h_o = h; sig_o = sg;
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            for (int r = 0; r < 4; r++) begin
                m_valid[i][r] = 1'b0; m_mask[i][r] = 4'h0;
                m_match[i][r] = 4'h0; m_next[i][r] = 4'h0;
            end
        RESET_N = 1'b0; TLR = 1'b0; X = 4'h0;
        INTEST_SELECT = 1'b0; RUNBIST_SELECT = 1'b0; SETSTATE_SELECT = 1'b0;
        ASSIGN_STATE = 4'h0; BIST_LEN = 16'h0;
        set_cfg(1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 4'h0, 4'h0);

        repeat (2) @(posedge clk);
        #1;
        push("reset", 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        check_now();
        RESET_N = 1'b1;

        INTEST_SELECT = 1'b1; X = 4'hF;
        for (int k = 0; k < 3; k++) cyc($sformatf("unprog%0d", k), 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);

        INTEST_SELECT = 1'b0;
        set_cfg(1'b1, 4'h0, 2'd0, 1'b1, 4'hE, 4'h0, 4'h2);
        cyc("cfg_r0", 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        set_cfg(1'b1, 4'h0, 2'd1, 1'b1, 4'hF, 4'h1, 4'h9);
        cyc("cfg_r1", 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        set_cfg(1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 4'h0, 4'h0);

        INTEST_SELECT = 1'b1; X = 4'h1;
        cyc("prio", 4'h2, 1'b1, 1'b0, 1'b0, 16'h0);
        X = 4'h5;
        cyc("nomatch", 4'h2, 1'b0, 1'b0, 1'b0, 16'h0);

        SETSTATE_SELECT = 1'b1; ASSIGN_STATE = 4'hB;
        cyc("setstate", 4'hB, 1'b0, 1'b0, 1'b0, 16'h0);
        SETSTATE_SELECT = 1'b0; INTEST_SELECT = 1'b0; TLR = 1'b1;
        cyc("tlr", 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        TLR = 1'b0; INTEST_SELECT = 1'b1; X = 4'h1;
        cyc("tlr_prio", 4'h2, 1'b1, 1'b0, 1'b0, 16'h0);
        INTEST_SELECT = 1'b0;

        BIST_LEN = 16'd0; RUNBIST_SELECT = 1'b1;
        cyc("len0", 4'h0, 1'b0, 1'b0, 1'b1, 16'h0);
        cyc("len0_hold", 4'h0, 1'b0, 1'b0, 1'b1, 16'h0);
        RUNBIST_SELECT = 1'b0;
        cyc("len0_drop", 4'h0, 1'b0, 1'b0, 1'b1, 16'h0);

        bist_run("bist5", 16'd5, 5, b_s, b_h, b_sig);
        chk("bist5", "busy_len", 16'(busy_cycles), 16'd5);
        sig_first = b_sig;
        cyc("bist5_hold", b_s, b_h, 1'b0, 1'b1, b_sig);
        RUNBIST_SELECT = 1'b0;
        cyc("bist5_drop", b_s, b_h, 1'b0, 1'b1, b_sig);

        bist_run("rerun", 16'd5, 5, b_s, b_h, b_sig);
        chk("rerun", "sig_vs_first", SIGNATURE, sig_first);
        RUNBIST_SELECT = 1'b0;
        cyc("rerun_drop", b_s, b_h, 1'b0, 1'b1, b_sig);

        bist_run("abort", 16'd5, 2, b_s, b_h, b_sig);
        RUNBIST_SELECT = 1'b0;
        cyc("abort_drop", b_s, b_h, 1'b0, 1'b0, b_sig);
        cyc("abort_idle", b_s, b_h, 1'b0, 1'b0, b_sig);

        SETSTATE_SELECT = 1'b1; ASSIGN_STATE = 4'h4;
        set_cfg(1'b1, 4'h4, 2'd0, 1'b1, 4'hF, 4'h3, 4'h4);
        cyc("coll_set", 4'h4, 1'b0, 1'b0, 1'b0, b_sig);
        SETSTATE_SELECT = 1'b0; INTEST_SELECT = 1'b1; X = 4'h3;
        set_cfg(1'b1, 4'h4, 2'd0, 1'b1, 4'hF, 4'h3, 4'h7);
        cyc("coll_old", 4'h4, 1'b1, 1'b0, 1'b0, b_sig);
        set_cfg(1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 4'h0, 4'h0);
        cyc("coll_new", 4'h7, 1'b1, 1'b0, 1'b0, b_sig);
        INTEST_SELECT = 1'b0;

        push("async_rst", 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        #2;
        RESET_N = 1'b0;
        #1;
        check_now();
        @(posedge clk);
        #1;
        RESET_N = 1'b1; INTEST_SELECT = 1'b1; X = 4'h1;
        cyc("rules_cleared", 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
